// File: rtl/ctrl_seg_pkg.sv
// ctrl_seg_pkg
// Shared definitions for the EX->MEM->WB control segment chain: field
// widths and bit offsets of the packed control bundle, the default reset
// value and write-enable mask, and pack/unpack helpers.
package ctrl_seg_pkg;

    localparam int WB_SEL_W    = 2;
    localparam int LOAD_TYPE_W = 3;
    localparam int CACHE_WEN_W = 4;
    localparam int CTRL_W      = WB_SEL_W + LOAD_TYPE_W + 1 + CACHE_WEN_W;

    // Bundle layout, MSB first: {wb_select, load_type, reg_write_en, cache_write_en}
    localparam int CACHE_WEN_LSB = 0;
    localparam int REG_WEN_BIT   = CACHE_WEN_LSB + CACHE_WEN_W;
    localparam int LOAD_TYPE_LSB = REG_WEN_BIT + 1;
    localparam int WB_SEL_LSB    = LOAD_TYPE_LSB + LOAD_TYPE_W;

    localparam logic [CTRL_W-1:0] CTRL_RESET_VAL = 10'h000;
    // reg_write_en and cache_write_en
    localparam logic [CTRL_W-1:0] CTRL_WEN_MASK  = 10'h01F;

    typedef struct packed {
        logic [WB_SEL_W-1:0]    wb_select;
        logic [LOAD_TYPE_W-1:0] load_type;
        logic                   reg_write_en;
        logic [CACHE_WEN_W-1:0] cache_write_en;
    } ctrl_bundle_t;

    function automatic logic [CTRL_W-1:0] ctrl_pack(input ctrl_bundle_t b);
        return {b.wb_select, b.load_type, b.reg_write_en, b.cache_write_en};
    endfunction

    function automatic ctrl_bundle_t ctrl_unpack(input logic [CTRL_W-1:0] v);
        ctrl_bundle_t b;
        b.wb_select      = v[WB_SEL_LSB +: WB_SEL_W];
        b.load_type      = v[LOAD_TYPE_LSB +: LOAD_TYPE_W];
        b.reg_write_en   = v[REG_WEN_BIT];
        b.cache_write_en = v[CACHE_WEN_LSB +: CACHE_WEN_W];
        return b;
    endfunction

endpackage

// File: rtl/ctrl_seg_pipe_if.sv
// ctrl_seg_pipe_if
// Bundle of the control-segment chain signals.
//   master: decoder/hazard side, drives in_data/in_valid/bubble/flush and
//           observes stage contents, output bundle, error and squash count.
//   slave : the segment chain itself.
interface ctrl_seg_pipe_if #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
);
    logic [WIDTH-1:0]       in_data;
    logic                   in_valid;
    logic [DEPTH-1:0]       bubble;
    logic [DEPTH-1:0]       flush;
    logic [DEPTH*WIDTH-1:0] stage_data;
    logic [DEPTH-1:0]       stage_valid;
    logic [WIDTH-1:0]       out_data;
    logic                   out_valid;
    logic                   overwrite_err;
    logic [CNT_W-1:0]       squash_cnt;

    modport master (
        output in_data, in_valid, bubble, flush,
        input  stage_data, stage_valid, out_data, out_valid, overwrite_err, squash_cnt
    );

    modport slave (
        input  in_data, in_valid, bubble, flush,
        output stage_data, stage_valid, out_data, out_valid, overwrite_err, squash_cnt
    );
endinterface

// File: rtl/ctrl_seg_stage.sv
// ctrl_seg_stage
// One control segment register with its valid bit.
// Priority per edge: bubble (hold) > flush (load reset_val, invalid) > load source.
//   clk, rst           : clock, async active-high reset
//   src_data/src_valid : bundle from the previous stage (or pipe input)
//   bubble, flush      : per-stage hold / squash controls
//   q_data/q_valid     : registered stage contents
module ctrl_seg_stage
    import ctrl_seg_pkg::*;
#(
    parameter int               WIDTH     = CTRL_W,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] src_data,
    input  logic             src_valid,
    input  logic             bubble,
    input  logic             flush,
    output logic [WIDTH-1:0] q_data,
    output logic             q_valid
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_data  <= RESET_VAL;
            q_valid <= 1'b0;
        end else if (!bubble) begin
            if (flush) begin
                q_data  <= RESET_VAL;
                q_valid <= 1'b0;
            end else begin
                q_data  <= src_data;
                q_valid <= src_valid;
            end
        end
    end

endmodule

// File: rtl/ctrl_seg_pipe.sv
// ctrl_seg_pipe
// Parametrised control segment chain for the EX->MEM->WB control path.
// DEPTH ctrl_seg_stage instances carry a WIDTH-bit bundle; the top level
// adds lost-bundle detection, a saturating squash counter and write-enable
// masking of the output bundle when the last stage is invalid.
//   clk, rst : pipeline clock, async active-high reset
//   bus      : slave modport of ctrl_seg_pipe_if (inputs in_data, in_valid,
//              bubble, flush; outputs stage_data, stage_valid, out_data,
//              out_valid, overwrite_err, squash_cnt)
module ctrl_seg_pipe
    import ctrl_seg_pkg::*;
#(
    parameter int               WIDTH     = CTRL_W,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = CTRL_RESET_VAL,
    parameter logic [WIDTH-1:0] WEN_MASK  = CTRL_WEN_MASK,
    parameter int               CNT_W     = 16
) (
    input  logic          clk,
    input  logic          rst,
    ctrl_seg_pipe_if.slave bus
);

    logic [WIDTH-1:0]       sd [DEPTH];
    logic [DEPTH-1:0]       sv;
    logic [DEPTH*WIDTH-1:0] stage_flat;

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        logic [WIDTH-1:0] src_d;
        logic             src_v;

        if (g == 0) begin : g_head
            assign src_d = bus.in_data;
            assign src_v = bus.in_valid;
        end else begin : g_body
            assign src_d = sd[g-1];
            assign src_v = sv[g-1];
        end

        ctrl_seg_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .src_data  (src_d),
            .src_valid (src_v),
            .bubble    (bus.bubble[g]),
            .flush     (bus.flush[g]),
            .q_data    (sd[g]),
            .q_valid   (sv[g])
        );
    end

    always_comb begin
        stage_flat = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            stage_flat[i*WIDTH +: WIDTH] = sd[i];
        end
    end

    assign bus.stage_data  = stage_flat;
    assign bus.stage_valid = sv;
    assign bus.out_valid   = sv[DEPTH-1];
    assign bus.out_data    = sv[DEPTH-1] ? sd[DEPTH-1] : (sd[DEPTH-1] & ~WEN_MASK);

    // A valid bundle is lost when its stage advances into a holding
    // successor; a same-cycle flush of that stage turns it into a squash.
    if (DEPTH > 1) begin : g_ow
        logic ow_hit;
        logic ow_q;

        always_comb begin
            ow_hit = 1'b0;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                if (!bus.bubble[i-1] && bus.bubble[i] && sv[i-1] && !bus.flush[i-1]) begin
                    ow_hit = 1'b1;
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                ow_q <= 1'b0;
            end else begin
                ow_q <= ow_hit;
            end
        end

        assign bus.overwrite_err = ow_q;
    end else begin : g_no_ow
        assign bus.overwrite_err = 1'b0;
    end

    // Squash counter: sum one bit wider than the counter, then saturate.
    logic [CNT_W:0]   k;
    logic [CNT_W:0]   sum;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        k = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!bus.bubble[i] && bus.flush[i] && sv[i]) begin
                k = k + (CNT_W+1)'(1);
            end
        end
        sum   = {1'b0, cnt_q} + k;
        cnt_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.squash_cnt = cnt_q;

endmodule

// File: tb/tb_ctrl_seg_pipe.sv
// tb_ctrl_seg_pipe
// Directed bench for ctrl_seg_pipe: three instances (DEPTH=2/CNT_W=16,
// DEPTH=2/CNT_W=4, DEPTH=1/CNT_W=16) sharing clk/rst.
module tb_ctrl_seg_pipe;
    import ctrl_seg_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    ctrl_seg_pipe_if #(.WIDTH(10), .DEPTH(2), .CNT_W(16)) bus_a ();
    ctrl_seg_pipe_if #(.WIDTH(10), .DEPTH(2), .CNT_W(4))  bus_b ();
    ctrl_seg_pipe_if #(.WIDTH(10), .DEPTH(1), .CNT_W(16)) bus_c ();

    ctrl_seg_pipe #(.WIDTH(10), .DEPTH(2), .RESET_VAL(10'h000), .WEN_MASK(10'h01F), .CNT_W(16))
        u_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
    ctrl_seg_pipe #(.WIDTH(10), .DEPTH(2), .RESET_VAL(10'h000), .WEN_MASK(10'h01F), .CNT_W(4))
        u_b (.clk(clk), .rst(rst), .bus(bus_b.slave));
    ctrl_seg_pipe #(.WIDTH(10), .DEPTH(1), .RESET_VAL(10'h000), .WEN_MASK(10'h01F), .CNT_W(16))
        u_c (.clk(clk), .rst(rst), .bus(bus_c.slave));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        bus_a.in_data = '0; bus_a.in_valid = 1'b0; bus_a.bubble = '0; bus_a.flush = '0;
        bus_b.in_data = '0; bus_b.in_valid = 1'b0; bus_b.bubble = '0; bus_b.flush = '0;
        bus_c.in_data = '0; bus_c.in_valid = 1'b0; bus_c.bubble = '0; bus_c.flush = '0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        total_cnt++;
        if (bus_a.stage_valid !== 2'b00) $display("FAIL reset_valid got=%b exp=00", bus_a.stage_valid);
        else pass_cnt++;
        total_cnt++;
        if (bus_a.out_data !== 10'h000) $display("FAIL reset_out_data got=%h exp=000", bus_a.out_data);
        else pass_cnt++;
        total_cnt++;
        if (bus_a.squash_cnt !== 16'd0) $display("FAIL reset_squash got=%0d exp=0", bus_a.squash_cnt);
        else pass_cnt++;
        total_cnt++;
        if (bus_a.overwrite_err !== 1'b0) $display("FAIL reset_ow got=%b exp=0", bus_a.overwrite_err);
        else pass_cnt++;
        total_cnt++;
        if (bus_c.out_valid !== 1'b0 || bus_b.squash_cnt !== 4'd0)
            $display("FAIL reset_bc got=%b/%0d exp=0/0", bus_c.out_valid, bus_b.squash_cnt);
        else pass_cnt++;
        step();
        rst = 1'b0;

        // Mid-stream reset with a valid 3FF in flight
        bus_a.in_data = 10'h3FF; bus_a.in_valid = 1'b1;
        step();
        step();
        total_cnt++;
        if (bus_a.out_data !== 10'h3FF || bus_a.out_valid !== 1'b1)
            $display("FAIL stream_3ff got=%h/%b exp=3ff/1", bus_a.out_data, bus_a.out_valid);
        else pass_cnt++;
        #3 rst = 1'b1;
        #1;
        total_cnt++;
        if (bus_a.stage_valid !== 2'b00) $display("FAIL midrst_valid got=%b exp=00", bus_a.stage_valid);
        else pass_cnt++;
        total_cnt++;
        if (bus_a.out_data !== 10'h000) $display("FAIL midrst_out got=%h exp=000", bus_a.out_data);
        else pass_cnt++;
        total_cnt++;
        if (bus_a.stage_data !== 20'h00000) $display("FAIL midrst_stage got=%h exp=00000", bus_a.stage_data);
        else pass_cnt++;
        total_cnt++;
        if (bus_a.squash_cnt !== 16'd0) $display("FAIL midrst_squash got=%0d exp=0", bus_a.squash_cnt);
        else pass_cnt++;
        idle_all();
        step();
        rst = 1'b0;
    endtask

    task automatic test_streaming();
        bus_a.in_data = ctrl_pack(ctrl_unpack(10'h155)); bus_a.in_valid = 1'b1;
        step();
        bus_a.in_data = 10'h2AA;
        step();
        total_cnt++;
        if (bus_a.out_data !== 10'h155 || bus_a.out_valid !== 1'b1)
            $display("FAIL stream_first got=%h/%b exp=155/1", bus_a.out_data, bus_a.out_valid);
        else pass_cnt++;
        bus_a.in_data = 10'h000; bus_a.in_valid = 1'b0;
        step();
        total_cnt++;
        if (bus_a.out_data !== 10'h2AA || bus_a.out_valid !== 1'b1)
            $display("FAIL stream_second got=%h/%b exp=2aa/1", bus_a.out_data, bus_a.out_valid);
        else pass_cnt++;
        step();
        total_cnt++;
        if (bus_a.out_valid !== 1'b0) $display("FAIL stream_drain got=%b exp=0", bus_a.out_valid);
        else pass_cnt++;
    endtask

    task automatic test_bubble_precedence();
        bus_a.in_data = 10'h0FF; bus_a.in_valid = 1'b1;
        step();
        bus_a.in_data = 10'h000; bus_a.in_valid = 1'b0;
        step();
        bus_a.bubble = 2'b10; bus_a.flush = 2'b10;
        for (int n = 0; n < 3; n++) begin
            step();
            total_cnt++;
            if (bus_a.stage_data[19:10] !== 10'h0FF || bus_a.stage_valid[1] !== 1'b1)
                $display("FAIL bubble_hold%0d got=%h/%b exp=0ff/1", n, bus_a.stage_data[19:10], bus_a.stage_valid[1]);
            else pass_cnt++;
            total_cnt++;
            if (bus_a.squash_cnt !== 16'd0) $display("FAIL bubble_squash%0d got=%0d exp=0", n, bus_a.squash_cnt);
            else pass_cnt++;
        end
        bus_a.bubble = 2'b00; bus_a.flush = 2'b00;
    endtask

    task automatic test_mask();
        bus_a.in_data = 10'h3FF; bus_a.in_valid = 1'b0;
        step();
        step();
        total_cnt++;
        if (bus_a.out_data !== 10'h3E0 || bus_a.out_valid !== 1'b0)
            $display("FAIL mask_out got=%h/%b exp=3e0/0", bus_a.out_data, bus_a.out_valid);
        else pass_cnt++;
        total_cnt++;
        if (bus_a.stage_data[19:10] !== 10'h3FF) $display("FAIL mask_stage got=%h exp=3ff", bus_a.stage_data[19:10]);
        else pass_cnt++;
    endtask

    task automatic test_flush_count();
        bus_a.in_data = 10'h3C3; bus_a.in_valid = 1'b1;
        step();
        bus_a.in_data = 10'h0A5;
        step();
        total_cnt++;
        if (bus_a.stage_valid !== 2'b11 || bus_a.out_data !== 10'h3C3)
            $display("FAIL flush_pre got=%b/%h exp=11/3c3", bus_a.stage_valid, bus_a.out_data);
        else pass_cnt++;
        bus_a.in_valid = 1'b0; bus_a.flush = 2'b11;
        step();
        bus_a.flush = 2'b00;
        total_cnt++;
        if (bus_a.stage_valid !== 2'b00) $display("FAIL flush_valid got=%b exp=00", bus_a.stage_valid);
        else pass_cnt++;
        total_cnt++;
        if (bus_a.squash_cnt !== 16'd2) $display("FAIL flush_squash got=%0d exp=2", bus_a.squash_cnt);
        else pass_cnt++;
        total_cnt++;
        if (bus_a.out_data[4:0] !== 5'b00000 || bus_a.out_data !== 10'h000)
            $display("FAIL flush_out got=%h exp=000", bus_a.out_data);
        else pass_cnt++;
    endtask

    task automatic test_overwrite();
        bus_a.in_data = 10'h155; bus_a.in_valid = 1'b1;
        step();
        bus_a.in_valid = 1'b0; bus_a.bubble = 2'b10;
        step();
        total_cnt++;
        if (bus_a.overwrite_err !== 1'b1) $display("FAIL ow_set got=%b exp=1", bus_a.overwrite_err);
        else pass_cnt++;
        bus_a.bubble = 2'b00;
        step();
        total_cnt++;
        if (bus_a.overwrite_err !== 1'b0) $display("FAIL ow_pulse got=%b exp=0", bus_a.overwrite_err);
        else pass_cnt++;

        bus_a.in_valid = 1'b1;
        step();
        bus_a.in_valid = 1'b0; bus_a.bubble = 2'b10; bus_a.flush = 2'b01;
        step();
        total_cnt++;
        if (bus_a.overwrite_err !== 1'b0) $display("FAIL ow_flush got=%b exp=0", bus_a.overwrite_err);
        else pass_cnt++;
        total_cnt++;
        if (bus_a.squash_cnt !== 16'd3) $display("FAIL ow_squash got=%0d exp=3", bus_a.squash_cnt);
        else pass_cnt++;
        bus_a.bubble = 2'b00; bus_a.flush = 2'b00;
        step();
        total_cnt++;
        if (bus_a.overwrite_err !== 1'b0) $display("FAIL ow_after got=%b exp=0", bus_a.overwrite_err);
        else pass_cnt++;
    endtask

    task automatic test_saturation();
        int exp_cnt;
        for (int r = 1; r <= 9; r++) begin
            bus_b.in_data = 10'h0A5; bus_b.in_valid = 1'b1;
            step();
            step();
            bus_b.in_valid = 1'b0; bus_b.flush = 2'b11;
            step();
            bus_b.flush = 2'b00;
            exp_cnt = (2 * r > 15) ? 15 : 2 * r;
            total_cnt++;
            if (bus_b.squash_cnt !== 4'(exp_cnt))
                $display("FAIL sat_round%0d got=%0d exp=%0d", r, bus_b.squash_cnt, exp_cnt);
            else pass_cnt++;
        end
    endtask

    task automatic test_depth1();
        bus_c.in_data = 10'h2AA; bus_c.in_valid = 1'b1;
        step();
        total_cnt++;
        if (bus_c.out_data !== 10'h2AA || bus_c.out_valid !== 1'b1)
            $display("FAIL d1_latency got=%h/%b exp=2aa/1", bus_c.out_data, bus_c.out_valid);
        else pass_cnt++;
        bus_c.in_valid = 1'b0; bus_c.bubble = 1'b1; bus_c.flush = 1'b1;
        step();
        total_cnt++;
        if (bus_c.out_data !== 10'h2AA || bus_c.out_valid !== 1'b1 || bus_c.overwrite_err !== 1'b0)
            $display("FAIL d1_hold got=%h/%b/%b exp=2aa/1/0", bus_c.out_data, bus_c.out_valid, bus_c.overwrite_err);
        else pass_cnt++;
        bus_c.bubble = 1'b0;
        step();
        bus_c.flush = 1'b0;
        total_cnt++;
        if (bus_c.out_data !== 10'h000 || bus_c.out_valid !== 1'b0 || bus_c.squash_cnt !== 16'd1)
            $display("FAIL d1_flush got=%h/%b/%0d exp=000/0/1", bus_c.out_data, bus_c.out_valid, bus_c.squash_cnt);
        else pass_cnt++;
    endtask

    initial begin
        idle_all();
        test_reset();
        test_streaming();
        test_bubble_precedence();
        test_mask();
        test_flush_count();
        test_overwrite();
        test_saturation();
        test_depth1();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/ctrl_seg_pipe.md
# ctrl_seg_pipe

Parametrised control-signal segment register chain for the EX→MEM→WB control path, replacing per-stage hand-written control segment registers. Carries a WIDTH-bit packed control bundle through DEPTH stages, each with its own bubble (hold) and flush (squash) input and a per-stage valid bit. Write-enable fields are forced inactive for invalid slots. A saturating counter records how many valid bundles were squashed by flushes. Sits between the decoder/hazard unit and the MEM/WB consumers of wb_select, load_type, reg_write_en and cache_write_en.

## Interface
- WIDTH, 10: packed bundle width, {wb_select[1:0], load_type[2:0], reg_write_en, cache_write_en[3:0]} by default.
- DEPTH, 2: number of segment stages; legal 1..8.
- RESET_VAL, 10'h000: bundle value loaded on reset and on flush.
- WEN_MASK, 10'h01F: bits cleared on the output when the last stage is invalid (reg_write_en and cache_write_en).
- CNT_W, 16: squash counter width.
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  WIDTH  bundle from decode/EX.
- in_valid  in  1  in_data holds a real instruction.
- bubble  in  DEPTH  bubble[i]=1: stage i holds its contents.
- flush  in  DEPTH  flush[i]=1: stage i loads RESET_VAL, valid 0.
- stage_data  out  DEPTH*WIDTH  all stage contents, stage i at [i*WIDTH +: WIDTH].
- stage_valid  out  DEPTH  per-stage valid.
- out_data  out  WIDTH  last stage bundle, WEN_MASK bits cleared when invalid.
- out_valid  out  1  = stage_valid[DEPTH-1].
- overwrite_err  out  1  registered pulse: a valid bundle was lost by an advancing stage over a holding successor.
- squash_cnt  out  CNT_W  saturating count of squashed valid bundles.

## Operation
- Stage 0 source is {in_data, in_valid}. The source for stage i>0 is stage i-1.
- Per stage on rising clk, priority order:
  - bubble[i]=1: hold data and valid. Bubble overrides flush, matching existing segment-register semantics.
  - Otherwise, flush[i]=1: data←RESET_VAL, valid←0.
  - Otherwise: data and valid ← source.
- Lost-data rule: stage i-1 advances (bubble[i-1]=0) while stage i holds (bubble[i]=1) and stage i-1 was valid.
  - The old stage i-1 bundle is discarded, not forwarded.
  - The hazard unit must prevent this. The block flags it via overwrite_err on the next cycle.
  - A flush on stage i-1 in the same cycle suppresses the flag.
- Squash counting:
  - Each cycle, k = number of stages with !bubble[i] && flush[i] && stage_valid[i].
  - squash_cnt ← min(squash_cnt + k, 2^CNT_W-1). The sum is computed at CNT_W+1 bits, then saturated.
- out_data = stage_valid[DEPTH-1] ? stage_data[last] : stage_data[last] & ~WEN_MASK (combinational).

## Timing
- Reset (async assert, sync-safe deassert by the system):
  - All stage data = RESET_VAL; stage_valid = 0; out_valid = 0.
  - out_data = RESET_VAL & ~WEN_MASK; overwrite_err = 0; squash_cnt = 0.
- Latency: with no bubbles, in_data at edge n appears on out_data after edge n+DEPTH-1, i.e. DEPTH cycles.
- Throughput: one bundle per cycle.
- Reset mid-operation: all in-flight bundles are discarded immediately, with no squash_cnt update.
- All stages flushed in one cycle: everything is invalid next cycle, and k counts only the valid, unbubbled stages.
- Counter at max: stays at 2^CNT_W-1 and never wraps.
- DEPTH=1: stage 0 is the output stage, and overwrite_err is constant 0.

## Structure
- Package ctrl_seg_pkg:
  - Field widths and offsets: WB_SEL_W=2, LOAD_TYPE_W=3, CACHE_WEN_W=4, CTRL_W=10.
  - Default CTRL_RESET_VAL and CTRL_WEN_MASK.
  - Pack/unpack functions for the bundle.
- Sub-module ctrl_seg_stage: one stage implementing hold/flush/load priority plus the valid bit, instantiated DEPTH times by a generate loop.
- The top level owns the overwrite detection, squash counter and output masking.

## Test plan
- Reset: assert rst mid-stream with a valid 10'h3FF in flight -> stage_valid=0, out_data=10'h000, squash_cnt=0, with no clk edge needed.
- Streaming, DEPTH=2: feed 10'h155, 10'h2AA valid on consecutive cycles -> out_data shows 10'h155 two edges later, then 10'h2AA, with out_valid=1 for each.
- Bubble precedence: bubble[1]=1 and flush[1]=1 with stage 1 valid 10'h0FF -> stage 1 holds 10'h0FF for every bubbled cycle, and squash_cnt is unchanged.
- Flush counting: stages 0 and 1 both valid, flush=2'b11, bubble=0 -> both invalid next cycle, squash_cnt+=2, and out_data has bits [4:0]=0.
- Saturation: CNT_W=4 with squash_cnt=14, then flush two valid stages -> squash_cnt=15; a further flush keeps it at 15.
- Overwrite: stage 0 valid, bubble=2'b10, flush=0 -> overwrite_err=1 for exactly one cycle; repeating with flush[0]=1 -> overwrite_err stays 0.
